// File: rtl/novacore_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : novacore_cfg_loader
// Description : Configuration sequencer for the NovaCORE fabric. Collects
//               host bytes (valid/ready) into per-cell frames, presents each
//               frame on c_bus/c_uid and strobes it with a generated c_clk
//               pulse. After the last cell, mode switches to run.
// Ports       : clk, rst_n (async, active low)
//               start               - one-cycle load request (ignored if busy)
//               in_data/in_valid    - host byte stream
//               in_ready            - high while collecting frame bytes
//               mode                - 0 configure/hold, 1 run
//               c_bus/c_uid/c_clk   - fabric configuration port
//               busy/done/err       - load status
// Options     : NOVACORE_CFG_CHECK_EN - each frame carries a trailing XOR
//               check byte; a mismatch aborts the load and sets err.
// Revision    : 1.0 - initial release
// ============================================================================
module novacore_cfg_loader #(
   parameter int BUS_W     = 82,
   parameter int UID_W     = 9,
   parameter int NUM_CELLS = 100,
   parameter int IN_W      = 8,
   parameter int CCLK_HALF = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             mode,
   output logic [BUS_W-1:0] c_bus,
   output logic [UID_W-1:0] c_uid,
   output logic             c_clk,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int C_NB = (BUS_W + IN_W - 1) / IN_W;
`ifdef NOVACORE_CFG_CHECK_EN
   // All NB data bytes stay in the register; the check byte is compared, not stored.
   localparam int C_LAST  = C_NB;
   localparam int C_FRM_W = C_NB * IN_W;
`else
   // The last data byte goes straight from in_data to c_bus, so only NB-1 are stored.
   localparam int C_LAST  = C_NB - 1;
   localparam int C_FRM_W = (C_NB - 1) * IN_W;
`endif
   localparam int C_CNT_W = $clog2(C_NB + 2);
   localparam int C_PH_W  = $clog2(CCLK_HALF + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [C_CNT_W-1:0] r_byte_cnt;
   logic [C_PH_W-1:0]  r_phase;
   logic [C_FRM_W-1:0] r_frame;

   logic w_accept;
   logic w_data_byte;
   logic w_last_byte;
   logic w_phase_end;
   logic w_last_cell;
   logic w_chk_ok;
   logic w_start_load;
   logic w_to_setup;
   logic w_chk_fail;
   logic w_next_cell;
   logic w_to_finish;

   assign w_accept    = (r_state == S_LOAD) && in_valid;
   assign w_last_byte = w_accept && (r_byte_cnt == C_CNT_W'(C_LAST));
   assign w_phase_end = (r_phase == C_PH_W'(CCLK_HALF - 1));
   assign w_last_cell = (c_uid == UID_W'(NUM_CELLS - 1));

`ifdef NOVACORE_CFG_CHECK_EN
   logic [IN_W-1:0] r_xor;
   assign w_data_byte = w_accept && (r_byte_cnt != C_CNT_W'(C_LAST));
   assign w_chk_ok    = (in_data == r_xor);
`else
   assign w_data_byte = w_accept;
   assign w_chk_ok    = 1'b1;
   assign err         = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // ------------------------------------------------------------------------
   // Next state and transition strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      w_start_load = 1'b0;
      w_to_setup   = 1'b0;
      w_chk_fail   = 1'b0;
      w_next_cell  = 1'b0;
      w_to_finish  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_LOAD;
               w_start_load = 1'b1;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (w_last_byte) begin
               if (w_chk_ok) begin
                  w_state_next = S_SETUP;
                  w_to_setup   = 1'b1;
               end else begin
                  w_state_next = S_IDLE;
                  w_chk_fail   = 1'b1;
               end
            end
         end
         S_SETUP:  if (w_phase_end) w_state_next = S_STROBE;
         S_STROBE: if (w_phase_end) w_state_next = S_HOLD;
         S_HOLD: begin
            if (w_phase_end) begin
               if (w_last_cell) begin
                  w_state_next = S_FINISH;
                  w_to_finish  = 1'b1;
               end else begin
                  w_state_next = S_LOAD;
                  w_next_cell  = 1'b1;
               end
            end
         end
         S_FINISH: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode       <= 1'b0;
         c_bus      <= '0;
         c_uid      <= '0;
         c_clk      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         r_byte_cnt <= '0;
         r_phase    <= '0;
         r_frame    <= '0;
      end else begin
         done <= 1'b0;

         if (w_start_load) begin
            mode       <= 1'b0;
            c_uid      <= '0;
            busy       <= 1'b1;
            r_byte_cnt <= '0;
         end

         if (w_accept)
            r_byte_cnt <= r_byte_cnt + C_CNT_W'(1);

         // Little-endian assembly: each new byte enters at the top and the
         // register shifts down, so byte 0 ends up in the lowest lane.
         if (w_data_byte)
            r_frame <= C_FRM_W'({in_data, r_frame} >> IN_W);

         if (w_to_setup) begin
`ifdef NOVACORE_CFG_CHECK_EN
            c_bus <= r_frame[BUS_W-1:0];
`else
            c_bus <= BUS_W'({in_data, r_frame});
`endif
         end

         if ((r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD))
            r_phase <= w_phase_end ? '0 : r_phase + C_PH_W'(1);
         else
            r_phase <= '0;

         if ((r_state == S_SETUP) && w_phase_end)  c_clk <= 1'b1;
         if ((r_state == S_STROBE) && w_phase_end) c_clk <= 1'b0;

         if (w_next_cell) begin
            c_uid      <= c_uid + UID_W'(1);
            r_byte_cnt <= '0;
         end

         if (w_to_finish) begin
            mode <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
         end

         if (w_chk_fail)
            busy <= 1'b0;
      end
   end

`ifdef NOVACORE_CFG_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xor <= '0;
         err   <= 1'b0;
      end else begin
         if (w_start_load || w_next_cell) r_xor <= '0;
         else if (w_data_byte)            r_xor <= r_xor ^ in_data;
         if (w_start_load)    err <= 1'b0;
         else if (w_chk_fail) err <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_novacore_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_novacore_cfg_loader
// Description : Self-checking bench for novacore_cfg_loader at default
//               parameters. Table-driven full loads plus hand-written
//               sequences for ignored start, mid-strobe reset and (with
//               NOVACORE_CFG_CHECK_EN) check-byte mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_novacore_cfg_loader;

   localparam int BUS_W = 82;
   localparam int UID_W = 9;
   localparam int NC    = 100;
   localparam int IN_W  = 8;
   localparam int CH    = 2;
   localparam int NB    = (BUS_W + IN_W - 1) / IN_W;
`ifdef NOVACORE_CFG_CHECK_EN
   localparam int NB_TX = NB + 1;
`else
   localparam int NB_TX = NB;
`endif
   localparam int BASE_CYC = NC * (NB_TX + 3 * CH) + 1;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             start    = 1'b0;
   logic [IN_W-1:0]  in_data  = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             mode;
   logic [BUS_W-1:0] c_bus;
   logic [UID_W-1:0] c_uid;
   logic             c_clk;
   logic             busy;
   logic             done;
   logic             err;

   novacore_cfg_loader #(
      .BUS_W     (BUS_W),
      .UID_W     (UID_W),
      .NUM_CELLS (NC),
      .IN_W      (IN_W),
      .CCLK_HALF (CH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mode     (mode),
      .c_bus    (c_bus),
      .c_uid    (c_uid),
      .c_clk    (c_clk),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  first_rdy = 0;
   bit  arm_rdy   = 1'b0;
   bit  prev_cclk = 1'b0;
   bit  abort     = 1'b0;

   logic [UID_W-1:0] uid_q[$];
   logic [BUS_W-1:0] bus_q[$];
   logic [BUS_W-1:0] exp_bus_q[$];
   int               done_q[$];

   // Observer: records what the fabric would capture on each c_clk rise.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (c_clk && !prev_cclk) begin
         uid_q.push_back(c_uid);
         bus_q.push_back(c_bus);
      end
      prev_cclk = c_clk;
      if (arm_rdy && in_ready) begin
         first_rdy = cyc;
         arm_rdy   = 1'b0;
      end
      if (done) done_q.push_back(cyc);
   end

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall);
      int n;
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b0;
         chk("ready_during_stall", in_ready, 1);
         @(negedge clk);
      end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && !abort && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) chk("ready_wait", in_ready, 1);
      if (!abort) @(negedge clk);
   endtask

   // Starts a load and streams nframes frames. kind 0: frame i bytes = i+1,
   // kind 1: random bytes. stall_mode 0: none, 1: one idle cycle before each
   // byte after the first of frame 0, 2: random 0..2 idle cycles.
   task automatic load_send(input int kind, input int stall_mode, input int nframes,
                            input int bad_frame, output int stalls);
      logic [7:0]        bytes[NB];
      logic [8*NB-1:0]   w;
      logic [7:0]        x;
      logic [7:0]        b;
      int                s;
      stalls = 0;
      uid_q.delete();
      bus_q.delete();
      done_q.delete();
      exp_bus_q.delete();
      arm_rdy = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int f = 0; f < nframes && !abort; f++) begin
         w = '0;
         x = '0;
         for (int k = 0; k < NB; k++) begin
            bytes[k] = (kind == 0) ? 8'(f + 1) : 8'($urandom);
            w[k*8 +: 8] = bytes[k];
            x = x ^ bytes[k];
         end
         exp_bus_q.push_back(w[BUS_W-1:0]);
         for (int k = 0; k < NB_TX && !abort; k++) begin
            s = 0;
            if (k > 0) begin
               if (stall_mode == 1 && f == 0) s = 1;
               else if (stall_mode == 2)      s = $urandom_range(0, 2);
            end
            stalls += s;
            if (k < NB)             b = bytes[k];
            else if (f == bad_frame) b = x ^ 8'hFF;
            else                     b = x;
            send_byte(b, s);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic load_check(input int exp_strobes, input int exp_cycles);
      int n;
      n = 0;
      while (done_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done_q.size(), 1);
      @(negedge clk);
      chk("mode_run", mode, 1);
      chk("busy_low", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("err_clear", err, 0);
      repeat (5) @(negedge clk);
      chk("strobe_count", uid_q.size(), exp_strobes);
      for (int i = 0; i < uid_q.size() && i < exp_bus_q.size(); i++) begin
         chk($sformatf("uid[%0d]", i), uid_q[i], i);
         chk($sformatf("bus[%0d]", i), bus_q[i], exp_bus_q[i]);
      end
      chk("done_count", done_q.size(), 1);
      if (done_q.size() > 0)
         chk("load_cycles", done_q[0] - first_rdy + 1, exp_cycles);
   endtask

   typedef struct {
      int kind;
      int stall_mode;
      int exp_strobes;
      int exp_base_cycles;
   } vec_t;

   initial begin
      vec_t vecs[4];
      int   st;
      int   wn;

      vecs[0] = '{0, 0, NC, BASE_CYC};
      vecs[1] = '{0, 1, NC, BASE_CYC};
      vecs[2] = '{1, 0, NC, BASE_CYC};
      vecs[3] = '{1, 2, NC, BASE_CYC};

      // Reset: outputs at reset values; data offered while idle is refused.
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (2) @(negedge clk);
      chk("rst_mode", mode, 0);
      chk("rst_c_bus", c_bus, 0);
      chk("rst_c_uid", c_uid, 0);
      chk("rst_c_clk", c_clk, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_mode", mode, 0);
      chk("idle_c_clk", c_clk, 0);
      chk("idle_no_strobe", uid_q.size(), 0);
      in_valid = 1'b0;

      // Table-driven full loads.
      for (int v = 0; v < 4; v++) begin
         load_send(vecs[v].kind, vecs[v].stall_mode, NC, -1, st);
         load_check(vecs[v].exp_strobes, vecs[v].exp_base_cycles + st);
         if (vecs[v].kind == 0 && bus_q.size() > 0)
            chk("frame0_bus_const", bus_q[0], 82'h1_0101_0101_0101_0101_0101);
      end

      // start pulsed during frame 5 strobe must be ignored.
      fork
         load_send(1, 0, NC, -1, st);
         begin
            wn = 0;
            while (!(c_clk && c_uid == 5) && wn < 300) begin
               @(negedge clk);
               wn++;
            end
            if (wn >= 300) chk("strobe5_seen", c_clk, 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      load_check(NC, BASE_CYC + st);

      // Reset while c_clk is high on frame 3.
      abort = 1'b0;
      fork
         load_send(1, 0, NC, -1, st);
         begin
            wn = 0;
            while (!(c_clk && c_uid == 3) && wn < 300) begin
               @(negedge clk);
               wn++;
            end
            if (wn >= 300) chk("strobe3_seen", c_clk, 1);
            #1 rst_n = 1'b0;
            #1;
            chk("mrst_c_clk", c_clk, 0);
            chk("mrst_mode", mode, 0);
            chk("mrst_c_uid", c_uid, 0);
            chk("mrst_busy", busy, 0);
            chk("mrst_in_ready", in_ready, 0);
            chk("mrst_c_bus", c_bus, 0);
            abort = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
         end
      join
      abort = 1'b0;
      chk("mrst_strobes_before", uid_q.size(), 4);
      repeat (3) @(negedge clk);
      load_send(1, 2, NC, -1, st);
      load_check(NC, BASE_CYC + st);

`ifdef NOVACORE_CFG_CHECK_EN
      // Corrupted check byte on frame 2 aborts the load.
      load_send(1, 0, 3, 2, st);
      repeat (20) @(negedge clk);
      chk("chk_strobes", uid_q.size(), 2);
      chk("chk_err", err, 1);
      chk("chk_busy", busy, 0);
      chk("chk_mode", mode, 0);
      chk("chk_no_done", done_q.size(), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
